// File: rtl/regfile_sb_if.sv
// Datapath-side bundle for regfile_sb: one write port, two read ports with
// busy flags, PC reload input and the scoreboard mark strobe.
`timescale 1ns/1ps
interface regfile_sb_if #(
    parameter int N    = 32,
    parameter int NREG = 16
);
    localparam int AW = $clog2(NREG);

    logic          WE3;
    logic [AW-1:0] A1;
    logic [AW-1:0] A2;
    logic [AW-1:0] A3;
    logic [N-1:0]  WD3;
    logic [N-1:0]  R15;
    logic          mark_valid;
    logic [AW-1:0] mark_addr;
    logic [N-1:0]  RD1;
    logic [N-1:0]  RD2;
    logic          busy1;
    logic          busy2;
    logic          ready;

    modport master (
        output WE3, A1, A2, A3, WD3, R15, mark_valid, mark_addr,
        input  RD1, RD2, busy1, busy2, ready
    );

    modport slave (
        input  WE3, A1, A2, A3, WD3, R15, mark_valid, mark_addr,
        output RD1, RD2, busy1, busy2, ready
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard, post-reset zeroing sequencer
// and dedicated PC register. Define REGFILE_BYPASS_EN for write-through reads.
`timescale 1ns/1ps
module regfile_sb #(
    parameter int N    = 32,
    parameter int NREG = 16
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);
    localparam int            AW        = $clog2(NREG);
    localparam logic [AW-1:0] PC_IDX    = AW'(NREG - 1);
    localparam logic [AW-1:0] LAST_INIT = AW'(NREG - 2);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_next;
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;
    logic [N-1:0]    r_pc;
    logic [N-1:0]    r_mem [NREG];

    logic            w_ready;
    logic            w_wr_ok;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [N-1:0]    w_mem_data;

    assign w_ready = (r_state == ST_READY);
    assign w_wr_ok = bus.WE3 && (bus.A3 != PC_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_busy  <= '0;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_busy  <= w_busy_next;
            r_pc    <= bus.R15;
        end
    end

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_busy_next  = r_busy;
        w_mem_we     = 1'b0;
        w_mem_addr   = r_cnt;
        w_mem_data   = '0;
        case (r_state)
            ST_INIT: begin
                w_mem_we   = 1'b1;
                w_cnt_next = r_cnt + AW'(1);
                if (r_cnt == LAST_INIT) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (w_wr_ok) begin
                    w_mem_we                = 1'b1;
                    w_mem_addr              = bus.A3;
                    w_mem_data              = bus.WD3;
                    w_busy_next[bus.A3]     = 1'b0;
                end
                // A new producer issuing wins over the retiring write.
                if (bus.mark_valid && (bus.mark_addr != PC_IDX)) begin
                    w_busy_next[bus.mark_addr] = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    // NOTE: storage has no reset so it can map to RAM; the init sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_byp1;
    logic w_byp2;
    assign w_byp1 = w_ready && w_wr_ok && (bus.A1 == bus.A3);
    assign w_byp2 = w_ready && w_wr_ok && (bus.A2 == bus.A3);
`endif

    always_comb begin
        bus.RD1   = '0;
        bus.RD2   = '0;
        bus.busy1 = 1'b0;
        bus.busy2 = 1'b0;
        if (w_ready) begin
            bus.RD1   = (bus.A1 == PC_IDX) ? r_pc : r_mem[bus.A1];
            bus.RD2   = (bus.A2 == PC_IDX) ? r_pc : r_mem[bus.A2];
            bus.busy1 = r_busy[bus.A1];
            bus.busy2 = r_busy[bus.A2];
`ifdef REGFILE_BYPASS_EN
            if (w_byp1) begin
                bus.RD1   = bus.WD3;
                bus.busy1 = bus.mark_valid && (bus.mark_addr == bus.A1);
            end
            if (w_byp2) begin
                bus.RD2   = bus.WD3;
                bus.busy2 = bus.mark_valid && (bus.mark_addr == bus.A2);
            end
`endif
        end
    end

    assign bus.ready = w_ready;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a behavioural model checked every cycle,
// plus hand-computed literal expectations for each scenario.
`timescale 1ns/1ps
module tb_regfile_sb;
    localparam int N    = 32;
    localparam int NREG = 16;
    localparam int AW   = $clog2(NREG);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    regfile_sb_if #(.N(N), .NREG(NREG)) bus ();

    regfile_sb #(.N(N), .NREG(NREG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Model: after reset the file is all zero once NREG-1 edges have passed;
    // it only reacts to writes/marks once it is ready.
    logic [N-1:0] m_reg [NREG];
    bit           m_busy [NREG];
    logic [N-1:0] m_pc;
    int           m_edges;
    bit           m_armed;

    function automatic logic [N-1:0] exp_rd(input int a, input bit rdy, input bit byp);
        if (!rdy) return '0;
        if (a == NREG - 1) return m_pc;
        if (byp) return bus.WD3;
        return m_reg[a];
    endfunction

    function automatic bit exp_busy(input int a, input bit rdy, input bit byp);
        if (!rdy) return 1'b0;
        if (byp) return bus.mark_valid && (int'(bus.mark_addr) == a);
        return m_busy[a];
    endfunction

    initial begin
        m_armed = 1'b0;
        m_edges = 0;
        m_pc    = '0;
        forever begin
            @(negedge clk);
            if (m_armed) begin
                automatic bit rdy  = (m_edges >= NREG - 1);
                automatic bit wr   = rdy && bus.WE3 && (int'(bus.A3) != NREG - 1);
                automatic bit byp1 = BYP && wr && (bus.A1 == bus.A3);
                automatic bit byp2 = BYP && wr && (bus.A2 == bus.A3);
                check("cyc_ready", bus.ready, rdy);
                check("cyc_rd1", bus.RD1, exp_rd(int'(bus.A1), rdy, byp1));
                check("cyc_rd2", bus.RD2, exp_rd(int'(bus.A2), rdy, byp2));
                check("cyc_busy1", bus.busy1, exp_busy(int'(bus.A1), rdy, byp1));
                check("cyc_busy2", bus.busy2, exp_busy(int'(bus.A2), rdy, byp2));
            end
            // Inputs are stable until after the next rising edge: predict it now.
            if (rst) begin
                m_armed = 1'b1;
                m_edges = 0;
                m_pc    = '0;
                for (int i = 0; i < NREG; i++) begin
                    m_reg[i]  = '0;
                    m_busy[i] = 1'b0;
                end
            end else if (m_armed) begin
                m_pc = bus.R15;
                if (m_edges >= NREG - 1) begin
                    if (bus.WE3 && int'(bus.A3) != NREG - 1) begin
                        m_reg[bus.A3]  = bus.WD3;
                        m_busy[bus.A3] = 1'b0;
                    end
                    if (bus.mark_valid && int'(bus.mark_addr) != NREG - 1) begin
                        m_busy[bus.mark_addr] = 1'b1;
                    end
                end else begin
                    m_edges++;
                end
            end
        end
    end

    task automatic next_vec();
        @(posedge clk);
        #1;
        bus.WE3        = 1'b0;
        bus.mark_valid = 1'b0;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        n_checks       = 0;
        n_err          = 0;
        rst            = 1'b1;
        bus.WE3        = 1'b0;
        bus.A1         = '0;
        bus.A2         = '0;
        bus.A3         = '0;
        bus.WD3        = '0;
        bus.R15        = '0;
        bus.mark_valid = 1'b0;
        bus.mark_addr  = '0;

        // Reset state, then the init sweep.
        next_vec(); mid();
        check("rst_ready", bus.ready, 1'b0);
        check("rst_rd1", bus.RD1, 32'h0);
        check("rst_busy2", bus.busy2, 1'b0);
        next_vec(); rst = 1'b0; mid();
        for (int e = 1; e <= 15; e++) begin
            next_vec(); mid();
            check("init_ready", bus.ready, (e == 15));
        end
        for (int i = 0; i < 15; i++) begin
            next_vec(); bus.A1 = AW'(i); mid();
            check("init_zero", bus.RD1, 32'h0);
        end

        // Write then read.
        next_vec();
        bus.WE3 = 1'b1; bus.A3 = 4'd5; bus.WD3 = 32'hDEADBEEF; bus.A1 = 4'd5;
        mid();
        check("wr_same_cycle", bus.RD1, BYP ? 32'hDEADBEEF : 32'h0);
        next_vec(); mid();
        check("wr_after", bus.RD1, 32'hDEADBEEF);

        // PC register.
        next_vec(); bus.R15 = 32'h100; bus.A2 = 4'd15; mid();
        check("pc_before", bus.RD2, 32'h0);
        next_vec(); bus.R15 = 32'h104; mid();
        check("pc_first", bus.RD2, 32'h100);
        next_vec(); bus.WE3 = 1'b1; bus.A3 = 4'd15; bus.WD3 = 32'hFFFFFFFF; mid();
        check("pc_second", bus.RD2, 32'h104);
        next_vec(); mid();
        check("pc_no_write", bus.RD2, 32'h104);

        // Scoreboard.
        next_vec(); bus.mark_valid = 1'b1; bus.mark_addr = 4'd3; bus.A1 = 4'd3; mid();
        check("busy_pre", bus.busy1, 1'b0);
        next_vec(); mid();
        check("busy_set", bus.busy1, 1'b1);
        next_vec(); bus.WE3 = 1'b1; bus.A3 = 4'd3; bus.WD3 = 32'h33; mid();
        check("busy_wr_cycle", bus.busy1, BYP ? 1'b0 : 1'b1);
        next_vec(); mid();
        check("busy_cleared", bus.busy1, 1'b0);
        check("busy_cleared_rd", bus.RD1, 32'h33);
        next_vec();
        bus.mark_valid = 1'b1; bus.mark_addr = 4'd3;
        bus.WE3 = 1'b1; bus.A3 = 4'd3; bus.WD3 = 32'h44;
        mid();
        check("busy_both_cycle", bus.busy1, BYP ? 1'b1 : 1'b0);
        next_vec(); mid();
        check("busy_both_after", bus.busy1, 1'b1);
        check("busy_both_rd", bus.RD1, 32'h44);

        // Both read ports on one pending register.
        next_vec(); bus.mark_valid = 1'b1; bus.mark_addr = 4'd9; bus.A1 = 4'd9; bus.A2 = 4'd9; mid();
        next_vec(); mid();
        check("dual_busy1", bus.busy1, 1'b1);
        check("dual_busy2", bus.busy2, 1'b1);
        check("dual_rd_eq", bus.RD1, bus.RD2);
        check("dual_rd1", bus.RD1, 32'h0);

        // Fill every register, then read back.
        for (int i = 0; i < 15; i++) begin
            next_vec();
            bus.WE3 = 1'b1; bus.A3 = AW'(i); bus.WD3 = 32'h01010101 * i;
            bus.A1 = AW'(i); bus.A2 = AW'(14 - i);
            mid();
        end
        for (int i = 0; i < 15; i++) begin
            next_vec(); bus.A1 = AW'(i); bus.A2 = 4'd15; mid();
            check("readback", bus.RD1, 32'h01010101 * i);
        end
        check("readback_pc", bus.RD2, 32'h104);
        check("readback_busy9", m_busy[9] ? 1'b1 : bus.busy1, 1'b0);

        // Reset in the middle of operation.
        next_vec();
        bus.WE3 = 1'b1; bus.A3 = 4'd7; bus.WD3 = 32'h55;
        bus.mark_valid = 1'b1; bus.mark_addr = 4'd7;
        bus.A1 = 4'd7; bus.A2 = 4'd7;
        mid();
        next_vec(); rst = 1'b1; mid();
        check("pre_rst_busy2", bus.busy2, 1'b1);
        check("pre_rst_rd2", bus.RD2, 32'h55);
        next_vec();
        rst = 1'b0;
        bus.WE3 = 1'b1; bus.A3 = 4'd7; bus.WD3 = 32'hAA;
        bus.mark_valid = 1'b1; bus.mark_addr = 4'd7;
        mid();
        check("mid_rst_ready", bus.ready, 1'b0);
        check("mid_rst_busy2", bus.busy2, 1'b0);
        check("mid_rst_rd2", bus.RD2, 32'h0);
        for (int e = 1; e <= 15; e++) begin
            next_vec();
            if (e < 15) begin
                bus.WE3 = 1'b1; bus.A3 = 4'd7; bus.WD3 = 32'hAA;
                bus.mark_valid = 1'b1; bus.mark_addr = 4'd7;
            end
            mid();
            check("reinit_ready", bus.ready, (e == 15));
        end
        check("reinit_rd2", bus.RD2, 32'h0);
        check("reinit_busy2", bus.busy2, 1'b0);
        next_vec(); mid();
        check("reinit_hold_rd1", bus.RD1, 32'h0);
        check("reinit_hold_busy1", bus.busy1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
